mda_hdmi_ctrl: RTL
==================

MDA_HDMI_CTRL -- requirements
Module: mda_hdmi_ctrl

Interface
REQ-001 Parameter DEBOUNCE_W, default 16, width of the switch debounce counter; a switch change commits after 2^DEBOUNCE_W-1 stable cycles.
REQ-002 Parameter TIMEOUT_W, default 19, width of the vsync-absence timeout counter.
REQ-003 Parameter MIN_LINES, default 340, minimum hsync count per frame for a good frame.
REQ-004 Parameter MAX_LINES, default 380, maximum hsync count per frame for a good frame.
REQ-005 Parameter LOCK_FRAMES, default 4, consecutive good frames required to enter ON; range 1..15.
REQ-006 clk  input  1  pixel clock; all logic on rising edge.
REQ-007 reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-008 hsync  input  1  CRTC horizontal sync, active high, synchronous to clk.
REQ-009 vsync  input  1  CRTC vertical sync, active high, synchronous to clk.
REQ-010 switch2  input  1  raw colour-select switch, asynchronous.
REQ-011 switch3  input  1  raw colour-select switch, asynchronous.
REQ-012 rgb_mask  output  3  {red,grn,blu} enables for the HDMI port colour gating.
REQ-013 hdmi_pd  output  1  transmitter power control, 1 = powered.
REQ-014 de_gate  output  1  1 = pass display_enable to the transmitter.
REQ-015 locked  output  1  1 = state ON.
REQ-016 state  output  2  current state code: OFF=0, ACQUIRE=1, ON=2.

Function
REQ-017 switch2/switch3 SHALL pass through a 2-flop synchroniser before any other use.
REQ-018 Debounce: synchronised pair differing from candidate SHALL load candidate and clear counter; otherwise counter increments, saturating at all-ones.
REQ-019 On the cycle the counter becomes all-ones, sw_stable SHALL load candidate.
REQ-020 Colour map of sw_stable {switch2,switch3}: 00 green 010, 01 yellow 110, 10 white 111, 11 red 100.
REQ-021 hsync/vsync rising edges SHALL be detected with one register stage; edge pulses are one cycle wide.
REQ-022 Line counter: 10 bits, increments per hsync rise, saturates at 1023.
REQ-023 On a vsync rise the line count SHALL be evaluated (good iff MIN_LINES <= count <= MAX_LINES), then cleared.
REQ-024 Simultaneous hsync and vsync rise: evaluation uses the old count; the new count becomes 1.
REQ-025 Timeout counter: cleared on vsync rise, else increments, saturating at all-ones; the cycle it becomes all-ones raises a one-cycle timeout event.
REQ-026 OFF: hdmi_pd=0, de_gate=0, rgb_mask=000; first vsync rise -> ACQUIRE, good_cnt=0; that edge is not evaluated.
REQ-027 ACQUIRE: outputs as OFF; good frame increments good_cnt; bad frame clears it.
REQ-028 ACQUIRE: a good frame making good_cnt equal LOCK_FRAMES -> ON; rgb_mask loads the colour map in the same cycle.
REQ-029 ON: hdmi_pd=1, de_gate=1, locked=1; rgb_mask SHALL load the colour map only on good-frame vsync rises.
REQ-030 ON: a bad frame -> ACQUIRE with good_cnt=0; rgb_mask=000 from the next cycle.
REQ-031 A timeout event in any state -> OFF; timeout has priority over a same-cycle vsync rise.
REQ-032 All outputs SHALL be registered; state-change effects appear on outputs one cycle after the triggering edge pulse.

Reset
REQ-033 Reset SHALL force state OFF, hdmi_pd=0, de_gate=0, locked=0, rgb_mask=000, sw_stable=00, and clear candidate, all counters and edge registers.
REQ-034 Reset asserted mid-operation SHALL take effect without a clock edge; after release, operation restarts from OFF.

Verification
REQ-035 Bench parameters: DEBOUNCE_W=4, TIMEOUT_W=8, MIN_LINES=4, MAX_LINES=6, LOCK_FRAMES=2; frames of 5 hsyncs per 100 cycles.
REQ-036 Scenario 1: reset, 4 good frames -> OFF->ACQUIRE at first vsync, ON after the 3rd vsync rise, hdmi_pd=1, rgb_mask=010.
REQ-037 Scenario 2: in ON, set switch2=1 for 20 cycles -> sw_stable=10 after 2 sync + 15 stable cycles, rgb_mask=111 only at the next vsync rise.
REQ-038 Scenario 3: switch glitch held 10 cycles then reverted -> sw_stable unchanged.
REQ-039 Scenario 4: in ON, one frame with 8 hsyncs -> ACQUIRE, hdmi_pd=0, rgb_mask=000; 2 further good frames -> ON.
REQ-040 Scenario 5: stop vsync in ON -> timeout event 255 cycles after last vsync rise, state OFF, then restart on the next vsync.
REQ-041 Scenario 6: hsync and vsync rise together on a frame with 5 prior lines -> frame good, next count starts at 1; reset pulse mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/mda_hdmi_ctrl.sv
// ---------------------------------------------------------------------------
// mda_hdmi_ctrl
//   Supervises the HDMI transmitter attached to an MDA-style CRTC. It counts
//   hsync pulses per frame to decide whether the incoming timing is sane. It
//   powers up the transmitter only after LOCK_FRAMES consecutive good frames,
//   and drops back out on a bad frame or when vsync disappears. The two
//   colour-select switches are synchronised and debounced, and they are
//   applied to the colour gate only on good-frame vsync edges, so the colour
//   never changes mid-frame.
//
// Ports
//   clk       in   pixel clock, rising edge
//   reset     in   asynchronous active-high reset
//   hsync     in   CRTC horizontal sync (active high, clk domain)
//   vsync     in   CRTC vertical sync (active high, clk domain)
//   switch2   in   raw colour-select switch (asynchronous)
//   switch3   in   raw colour-select switch (asynchronous)
//   rgb_mask  out  {red,grn,blu} colour gate enables
//   hdmi_pd   out  transmitter power, 1 = powered
//   de_gate   out  1 = pass display_enable through
//   locked    out  1 = state ON
//   state     out  OFF=0, ACQUIRE=1, ON=2
// ---------------------------------------------------------------------------
module mda_hdmi_ctrl #(
  parameter int DEBOUNCE_W  = 16,
  parameter int TIMEOUT_W   = 19,
  parameter int MIN_LINES   = 340,
  parameter int MAX_LINES   = 380,
  parameter int LOCK_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       switch2,
  input  logic       switch3,
  output logic [2:0] rgb_mask,
  output logic       hdmi_pd,
  output logic       de_gate,
  output logic       locked,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_ON      = 2'd2
  } state_t;

  localparam logic [DEBOUNCE_W-1:0] DB_ONES  = '1;
  localparam logic [TIMEOUT_W-1:0]  TO_ONES  = '1;
  localparam logic [9:0]            LINE_SAT = 10'd1023;
  localparam logic [9:0]            MIN_L    = 10'(MIN_LINES);
  localparam logic [9:0]            MAX_L    = 10'(MAX_LINES);
  localparam logic [3:0]            LOCK_N   = 4'(LOCK_FRAMES);

  // Switch pair {switch2,switch3} to colour gate {red,grn,blu}.
  function automatic logic [2:0] colour_map(input logic [1:0] sw);
    case (sw)
      2'b00:   return 3'b010;  // green
      2'b01:   return 3'b110;  // yellow
      2'b10:   return 3'b111;  // white
      default: return 3'b100;  // red
    endcase
  endfunction

  logic [1:0]            sw_meta_q, sw_meta_d;
  logic [1:0]            sw_sync_q, sw_sync_d;
  logic [1:0]            sw_cand_q, sw_cand_d;
  logic [1:0]            sw_stable_q, sw_stable_d;
  logic [DEBOUNCE_W-1:0] db_cnt_q, db_cnt_d;
  logic                  hs_q, hs_d;
  logic                  vs_q, vs_d;
  logic [9:0]            lines_q, lines_d;
  logic [TIMEOUT_W-1:0]  to_cnt_q, to_cnt_d;
  state_t                state_q, state_d;
  logic [3:0]            good_cnt_q, good_cnt_d;
  logic [2:0]            rgb_mask_q, rgb_mask_d;
  logic                  hdmi_pd_q, hdmi_pd_d;
  logic                  de_gate_q, de_gate_d;
  logic                  locked_q, locked_d;

  logic hs_rise;
  logic vs_rise;
  logic frame_good;
  logic timeout_evt;

  // Input stage: switch synchroniser, debounce, sync edge detection.
  always_comb begin
    sw_meta_d   = {switch2, switch3};
    sw_sync_d   = sw_meta_q;
    hs_d        = hsync;
    vs_d        = vsync;
    hs_rise     = hsync & ~hs_q;
    vs_rise     = vsync & ~vs_q;

    sw_cand_d   = sw_cand_q;
    db_cnt_d    = db_cnt_q;
    sw_stable_d = sw_stable_q;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_d = sw_sync_q;
      db_cnt_d  = '0;
    end else if (db_cnt_q != DB_ONES) begin
      db_cnt_d = db_cnt_q + 1'b1;
      // Commit exactly once, on the cycle the count reaches all-ones.
      if (db_cnt_d == DB_ONES) begin
        sw_stable_d = sw_cand_q;
      end
    end
  end

  // Frame measurement: lines per frame and vsync-absence timeout.
  always_comb begin
    lines_d = lines_q;
    if (vs_rise) begin
      // A coincident hsync belongs to the frame that is just starting.
      lines_d = hs_rise ? 10'd1 : 10'd0;
    end else if (hs_rise && (lines_q != LINE_SAT)) begin
      lines_d = lines_q + 10'd1;
    end
    frame_good = (lines_q >= MIN_L) && (lines_q <= MAX_L);

    to_cnt_d    = to_cnt_q;
    timeout_evt = 1'b0;
    if (vs_rise) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_ONES) begin
      to_cnt_d    = to_cnt_q + 1'b1;
      timeout_evt = (to_cnt_d == TO_ONES);
    end
  end

  // Lock FSM and registered outputs.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    rgb_mask_d = rgb_mask_q;

    if (timeout_evt) begin
      state_d = ST_OFF;
    end else if (vs_rise) begin
      case (state_q)
        ST_OFF: begin
          // The first edge only marks a frame start; nothing to evaluate.
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
        ST_ACQUIRE: begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_d == LOCK_N) begin
              state_d    = ST_ON;
              rgb_mask_d = colour_map(sw_stable_q);
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_ON: begin
          if (frame_good) begin
            rgb_mask_d = colour_map(sw_stable_q);
          end else begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end

    if (state_d != ST_ON) begin
      rgb_mask_d = 3'b000;
    end
    hdmi_pd_d = (state_d == ST_ON);
    de_gate_d = (state_d == ST_ON);
    locked_d  = (state_d == ST_ON);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      sw_cand_q   <= '0;
      sw_stable_q <= '0;
      db_cnt_q    <= '0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      lines_q     <= '0;
      to_cnt_q    <= '0;
      state_q     <= ST_OFF;
      good_cnt_q  <= '0;
      rgb_mask_q  <= '0;
      hdmi_pd_q   <= 1'b0;
      de_gate_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sw_meta_q   <= sw_meta_d;
      sw_sync_q   <= sw_sync_d;
      sw_cand_q   <= sw_cand_d;
      sw_stable_q <= sw_stable_d;
      db_cnt_q    <= db_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      lines_q     <= lines_d;
      to_cnt_q    <= to_cnt_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      rgb_mask_q  <= rgb_mask_d;
      hdmi_pd_q   <= hdmi_pd_d;
      de_gate_q   <= de_gate_d;
      locked_q    <= locked_d;
    end
  end

  assign rgb_mask = rgb_mask_q;
  assign hdmi_pd  = hdmi_pd_q;
  assign de_gate  = de_gate_q;
  assign locked   = locked_q;
  assign state    = state_q;

endmodule
